// File: rtl/fft16_seq.sv
// fft16_seq -- sequential 16-point radix-2 decimation-in-time FFT.
//
// Collects 16 real signed samples through a valid/ready handshake.
// Each sample is stored in bit-reversed order in a 16-word complex
// working store. The frame is then transformed in place by one
// time-shared butterfly, one butterfly per clock, 32 clocks in all.
// The final stage also writes the 16 output registers, and fft_valid
// pulses for one cycle when the frame is complete.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST_N      asynchronous active-low reset
//   fir_valid  upstream sample present on fir_d
//   fir_d      signed 16-bit real sample
//   fir_ready  high while collecting samples (combinational from state)
//   fft_valid  one-cycle pulse: fft_d0..fft_d15 hold a new frame
//   fft_d0..15 bin k = {re[15:0], im[15:0]}, natural order
//
// Parameter:
//   TW_FRAC    fractional bits of the twiddle constants (right shift
//              applied after the twiddle multiply)
//
// Build option:
//   FFT_STAGE_SCALE_EN  when defined, every butterfly result is halved
//                       (1/16 overall) and cannot overflow. When
//                       undefined, results saturate to 16 bits instead.

module fft16_seq #(
  parameter int TW_FRAC = 14
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               fir_valid,
  input  logic signed [15:0] fir_d,
  output logic               fir_ready,
  output logic               fft_valid,
  output logic [31:0]        fft_d0,
  output logic [31:0]        fft_d1,
  output logic [31:0]        fft_d2,
  output logic [31:0]        fft_d3,
  output logic [31:0]        fft_d4,
  output logic [31:0]        fft_d5,
  output logic [31:0]        fft_d6,
  output logic [31:0]        fft_d7,
  output logic [31:0]        fft_d8,
  output logic [31:0]        fft_d9,
  output logic [31:0]        fft_d10,
  output logic [31:0]        fft_d11,
  output logic [31:0]        fft_d12,
  output logic [31:0]        fft_d13,
  output logic [31:0]        fft_d14,
  output logic [31:0]        fft_d15
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t      state_reg;
  logic [3:0]  load_cnt_reg;
  logic [4:0]  calc_cnt_reg;
  logic        fft_valid_reg;

  // In-place working store; it is completely rewritten by every frame,
  // so it carries no reset.
  logic signed [15:0] mem_re [16];
  logic signed [15:0] mem_im [16];

  // Packed copy of the 16 output registers, one 32-bit slot per bin.
  logic [511:0] fft_d_bus;

  // ---------------------------------------------------------------
  // Butterfly addressing
  // ---------------------------------------------------------------
  logic [1:0] stage;
  logic [2:0] bfly;
  logic [3:0] top_addr;
  logic [3:0] bot_addr;
  logic [2:0] tw_idx;

  // top = ((j >> s) << (s+1)) + (j & (half-1)) and k = pos << (3-s),
  // written out per stage as bit insertions. Bit s of top is always 0,
  // so the bottom partner is top with that bit set.
  always_comb begin
    stage    = calc_cnt_reg[4:3];
    bfly     = calc_cnt_reg[2:0];
    top_addr = 4'd0;
    tw_idx   = 3'd0;
    case (stage)
      2'd0: begin
        top_addr = {bfly, 1'b0};
        tw_idx   = 3'd0;
      end
      2'd1: begin
        top_addr = {bfly[2:1], 1'b0, bfly[0]};
        tw_idx   = {bfly[0], 2'b00};
      end
      2'd2: begin
        top_addr = {bfly[2], 1'b0, bfly[1:0]};
        tw_idx   = {bfly[1:0], 1'b0};
      end
      default: begin
        top_addr = {1'b0, bfly};
        tw_idx   = bfly;
      end
    endcase
    bot_addr = top_addr | (4'd1 << stage);
  end

  // ---------------------------------------------------------------
  // Twiddle ROM: W^k = cos - j*sin (2*pi*k/16), scaled by 2^14
  // ---------------------------------------------------------------
  logic signed [15:0] cos_w;
  logic signed [15:0] sin_w;

  always_comb begin
    cos_w = 16'sd16384;
    sin_w = 16'sd0;
    case (tw_idx)
      3'd0: begin cos_w =  16'sd16384; sin_w = 16'sd0;     end
      3'd1: begin cos_w =  16'sd15137; sin_w = 16'sd6270;  end
      3'd2: begin cos_w =  16'sd11585; sin_w = 16'sd11585; end
      3'd3: begin cos_w =  16'sd6270;  sin_w = 16'sd15137; end
      3'd4: begin cos_w =  16'sd0;     sin_w = 16'sd16384; end
      3'd5: begin cos_w = -16'sd6270;  sin_w = 16'sd15137; end
      3'd6: begin cos_w = -16'sd11585; sin_w = 16'sd11585; end
      default: begin cos_w = -16'sd15137; sin_w = 16'sd6270; end
    endcase
  end

  // ---------------------------------------------------------------
  // Butterfly datapath
  // ---------------------------------------------------------------
  // Clamp a wide result to the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      sat16 = 16'sh7fff;
    end else if (v < -32'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  logic signed [31:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [31:0] cos_x, sin_x;
  logic signed [31:0] t_re, t_im;
  logic signed [31:0] top_re_w, top_im_w, bot_re_w, bot_im_w;
  logic signed [15:0] top_re, top_im, bot_re, bot_im;

  always_comb begin
    a_re_x = 32'(mem_re[top_addr]);
    a_im_x = 32'(mem_im[top_addr]);
    b_re_x = 32'(mem_re[bot_addr]);
    b_im_x = 32'(mem_im[bot_addr]);
    cos_x  = 32'(cos_w);
    sin_x  = 32'(sin_w);

    // (b_re + j b_im)(cos - j sin); >>> rounds toward minus infinity.
    t_re = (b_re_x * cos_x + b_im_x * sin_x) >>> TW_FRAC;
    t_im = (b_im_x * cos_x - b_re_x * sin_x) >>> TW_FRAC;

    // Sums are carried wider than 17 bits so saturation sees the true
    // magnitude even when |t| exceeds full scale.
    top_re_w = a_re_x + t_re;
    top_im_w = a_im_x + t_im;
    bot_re_w = a_re_x - t_re;
    bot_im_w = a_im_x - t_im;

`ifdef FFT_STAGE_SCALE_EN
    // Halve every stage; the clamp below can then never engage.
    top_re_w = top_re_w >>> 1;
    top_im_w = top_im_w >>> 1;
    bot_re_w = bot_re_w >>> 1;
    bot_im_w = bot_im_w >>> 1;
`endif

    top_re = sat16(top_re_w);
    top_im = sat16(top_im_w);
    bot_re = sat16(bot_re_w);
    bot_im = sat16(bot_im_w);
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= S_LOAD;
      load_cnt_reg  <= 4'd0;
      calc_cnt_reg  <= 5'd0;
      fft_valid_reg <= 1'b0;
    end else begin
      fft_valid_reg <= 1'b0;
      case (state_reg)
        S_LOAD: begin
          if (fir_valid) begin
            load_cnt_reg <= load_cnt_reg + 4'd1;
            if (load_cnt_reg == 4'd15) begin
              state_reg    <= S_CALC;
              calc_cnt_reg <= 5'd0;
            end
          end
        end
        default: begin
          calc_cnt_reg <= calc_cnt_reg + 5'd1;
          if (calc_cnt_reg == 5'd31) begin
            state_reg     <= S_LOAD;
            fft_valid_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fir_ready = (state_reg == S_LOAD);
  assign fft_valid = fft_valid_reg;

  // ---------------------------------------------------------------
  // Working store: bit-reversed load, then in-place butterflies
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (state_reg == S_LOAD) begin
      if (fir_valid) begin
        mem_re[{load_cnt_reg[0], load_cnt_reg[1], load_cnt_reg[2], load_cnt_reg[3]}] <= fir_d;
        mem_im[{load_cnt_reg[0], load_cnt_reg[1], load_cnt_reg[2], load_cnt_reg[3]}] <= 16'sd0;
      end
    end else begin
      mem_re[top_addr] <= top_re;
      mem_im[top_addr] <= top_im;
      mem_re[bot_addr] <= bot_re;
      mem_im[bot_addr] <= bot_im;
    end
  end

  // ---------------------------------------------------------------
  // Output registers: loaded by the last stage alongside the store,
  // otherwise held, so the previous frame stays visible during the
  // next LOAD and CALC.
  // ---------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_out
      logic [31:0] fft_d_reg;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          fft_d_reg <= 32'd0;
        end else if (state_reg == S_CALC && stage == 2'd3) begin
          if (top_addr == 4'(gi)) begin
            fft_d_reg <= {top_re, top_im};
          end else if (bot_addr == 4'(gi)) begin
            fft_d_reg <= {bot_re, bot_im};
          end
        end
      end
      assign fft_d_bus[gi*32 +: 32] = fft_d_reg;
    end
  endgenerate

  assign fft_d0  = fft_d_bus[ 31:  0];
  assign fft_d1  = fft_d_bus[ 63: 32];
  assign fft_d2  = fft_d_bus[ 95: 64];
  assign fft_d3  = fft_d_bus[127: 96];
  assign fft_d4  = fft_d_bus[159:128];
  assign fft_d5  = fft_d_bus[191:160];
  assign fft_d6  = fft_d_bus[223:192];
  assign fft_d7  = fft_d_bus[255:224];
  assign fft_d8  = fft_d_bus[287:256];
  assign fft_d9  = fft_d_bus[319:288];
  assign fft_d10 = fft_d_bus[351:320];
  assign fft_d11 = fft_d_bus[383:352];
  assign fft_d12 = fft_d_bus[415:384];
  assign fft_d13 = fft_d_bus[447:416];
  assign fft_d14 = fft_d_bus[479:448];
  assign fft_d15 = fft_d_bus[511:480];

endmodule
